divisor_secuencial: RTL and testbench
=====================================

Name: divisor_secuencial

Overview:
- Iterative restoring divider for the RV32M DIV/DIVU/REM/REMU operations.
- The carry-lookahead adder serves the add direction; this block performs the inverse operation, one shift-subtract step per clock.
- Sits beside the ALU in the execute stage.
- Uses a valid/ready handshake on both sides so the pipeline stalls on it cleanly.

Parameters:
- N, 32, operand and result width in bits (N >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- InValido  input  1  request valid.
- InListo  output  1  block can accept a request.
- Operando1  input  N  dividend.
- Operando2  input  N  divisor.
- ConSigno  input  1  1 = signed (DIV/REM), 0 = unsigned.
- PideResto  input  1  1 = return remainder, 0 = return quotient.
- OutValido  output  1  Resultado valid.
- OutListo  input  1  consumer accepts the result.
- Resultado  output  N  quotient or remainder.
- DivCero  output  1  flag, valid with OutValido: divisor was zero.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - InListo = 1.
  - OutValido = 0, Resultado = 0, DivCero = 0.
  - All internal registers = 0.
- Reset mid-operation:
  - Aborts immediately; state returns to IDLE.
  - No result is produced for the aborted request.
- States: IDLE, CALC, SIGNO, DONE.
- InListo is 1 only in IDLE.
- Accept occurs on a rising edge with InValido=1 and InListo=1.
  - Operands, ConSigno and PideResto are captured at accept.
  - Later input changes are ignored.
- IDLE -> DONE on accept, special cases (bypass path):
  - Operando2 == 0: quotient = all ones, remainder = Operando1, DivCero=1. Same for signed and unsigned.
  - Signed overflow (ConSigno=1, Operando1 = 1 followed by N-1 zeros, Operando2 = all ones): quotient = Operando1, remainder = 0, DivCero=0.
  - Result is selected by PideResto.
  - OutValido rises 1 cycle after the accept edge.
- IDLE -> CALC on accept, all other cases:
  - Signed mode: take magnitudes of both operands.
  - Record signo_q = sign1 XOR sign2 and signo_r = sign1.
  - Clear the partial remainder R (N+1 bits); load Q = |dividend|; iteration counter = N-1.
- CALC, one iteration per cycle:
  - R = {R[N-1:0], Q[N-1]}; Q <<= 1.
  - If R >= |divisor|: R -= |divisor|, Q[0] = 1.
  - Counter decrements. The cycle in which counter == 0 performs the last iteration, then state -> SIGNO.
- SIGNO, one cycle:
  - Negate Q if signo_q; negate R if signo_r.
  - Load Resultado = PideResto ? R : Q; DivCero=0; state -> DONE.
  - In unsigned mode no negation is applied.
- Normal-path latency:
  - OutValido rises exactly N+2 cycles after the accept edge: N CALC + 1 SIGNO + registered output.
  - For N=32 this is 34 cycles.
- DONE:
  - OutValido=1.
  - Resultado and DivCero are held stable while OutValido=1 and OutListo=0.
  - On an edge with OutListo=1: OutValido -> 0, state -> IDLE, InListo -> 1 in the next cycle.
  - No back-to-back accept in the same cycle as result consumption; the minimum gap is one IDLE cycle.
- Remainder sign follows the dividend; quotient truncates toward zero (RISC-V semantics).
- Resultado holds its last value outside DONE. Consumers sample it only when OutValido=1.
- InValido while busy is ignored: no capture, no error. The requester must hold InValido until accepted.

Test Plan:
- Unsigned, N=32: Operando1=100, Operando2=7, PideResto=0 -> Resultado=14, OutValido high exactly 34 cycles after accept. Repeat with PideResto=1 -> Resultado=2.
- Signed: Operando1=-7 (0xFFFFFFF9), Operando2=2, ConSigno=1 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
- Divide by zero: Operando1=0x12345678, Operando2=0 -> quotient 0xFFFFFFFF, remainder 0x12345678, DivCero=1, OutValido 1 cycle after accept.
- Signed overflow: 0x80000000 / 0xFFFFFFFF, ConSigno=1 -> quotient 0x80000000, remainder 0, DivCero=0, 1-cycle latency.
- Backpressure: hold OutListo=0 for 10 cycles in DONE -> Resultado stable and InListo=0 throughout. Toggling InValido with new operands in that window has no effect on the pending result.
- Reset mid-CALC: drive rst_n=0 at iteration 5 -> outputs cleared asynchronously, InListo=1 after release. A new request 9/3 then returns 3 in 34 cycles.

Source files
------------

// File: rtl/divisor_secuencial.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one shift-subtract step per clock.
// Latency N+2 cycles accept-to-OutValido (1 for divide-by-zero/overflow); result held until OutListo.
module divisor_secuencial #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         InValido,
  output logic         InListo,
  input  logic [N-1:0] Operando1,
  input  logic [N-1:0] Operando2,
  input  logic         ConSigno,
  input  logic         PideResto,
  output logic         OutValido,
  input  logic         OutListo,
  output logic [N-1:0] Resultado,
  output logic         DivCero
);

  localparam int CW = $clog2(N);
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, SIGNO, DONE} state_t;

  state_t        state_q, state_d;
  logic [N:0]    r_q, r_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          signo_q, signo_d;
  logic          signo_r_q, signo_r_d;
  logic          pide_q, pide_d;
  logic [N-1:0]  resultado_q, resultado_d;
  logic          divcero_q, divcero_d;
  logic          out_valido_q, out_valido_d;
  logic          in_listo_q, in_listo_d;

  logic [N-1:0]  mag1, mag2;
  logic [N:0]    r_shift;
  logic [N-1:0]  q_shift;
  logic [N-1:0]  q_fin, r_fin;

  always_comb begin
    mag1    = (ConSigno && Operando1[N-1]) ? (~Operando1 + 1'b1) : Operando1;
    mag2    = (ConSigno && Operando2[N-1]) ? (~Operando2 + 1'b1) : Operando2;
    r_shift = {r_q[N-1:0], q_q[N-1]};
    q_shift = {q_q[N-2:0], 1'b0};
    q_fin   = signo_q   ? (~q_q + 1'b1) : q_q;
    r_fin   = signo_r_q ? (~r_q[N-1:0] + 1'b1) : r_q[N-1:0];
  end

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    q_d          = q_q;
    dvs_d        = dvs_q;
    cnt_d        = cnt_q;
    signo_d      = signo_q;
    signo_r_d    = signo_r_q;
    pide_d       = pide_q;
    resultado_d  = resultado_q;
    divcero_d    = divcero_q;
    out_valido_d = out_valido_q;
    in_listo_d   = in_listo_q;
    case (state_q)
      IDLE: begin
        if (InValido && in_listo_q) begin
          in_listo_d = 1'b0;
          pide_d     = PideResto;
          if (Operando2 == '0) begin
            resultado_d = PideResto ? Operando1 : '1;
            divcero_d   = 1'b1;
            state_d     = DONE;
          end else if (ConSigno && Operando1 == MIN_NEG && Operando2 == '1) begin
            resultado_d = PideResto ? '0 : Operando1;
            divcero_d   = 1'b0;
            state_d     = DONE;
          end else begin
            r_d       = '0;
            q_d       = mag1;
            dvs_d     = mag2;
            cnt_d     = CW'(N-1);
            signo_d   = ConSigno && (Operando1[N-1] ^ Operando2[N-1]);
            signo_r_d = ConSigno && Operando1[N-1];
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        // Restoring step: keep the subtraction only when it does not go negative.
        if (r_shift >= {1'b0, dvs_q}) begin
          r_d = r_shift - {1'b0, dvs_q};
          q_d = q_shift | {{(N-1){1'b0}}, 1'b1};
        end else begin
          r_d = r_shift;
          q_d = q_shift;
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = SIGNO;
      end
      SIGNO: begin
        resultado_d = pide_q ? r_fin : q_fin;
        divcero_d   = 1'b0;
        state_d     = DONE;
      end
      DONE: begin
        if (out_valido_q && OutListo) begin
          out_valido_d = 1'b0;
          in_listo_d   = 1'b1;
          state_d      = IDLE;
        end else begin
          out_valido_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      r_q          <= '0;
      q_q          <= '0;
      dvs_q        <= '0;
      cnt_q        <= '0;
      signo_q      <= 1'b0;
      signo_r_q    <= 1'b0;
      pide_q       <= 1'b0;
      resultado_q  <= '0;
      divcero_q    <= 1'b0;
      out_valido_q <= 1'b0;
      in_listo_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      q_q          <= q_d;
      dvs_q        <= dvs_d;
      cnt_q        <= cnt_d;
      signo_q      <= signo_d;
      signo_r_q    <= signo_r_d;
      pide_q       <= pide_d;
      resultado_q  <= resultado_d;
      divcero_q    <= divcero_d;
      out_valido_q <= out_valido_d;
      in_listo_q   <= in_listo_d;
    end
  end

  assign InListo   = in_listo_q;
  assign OutValido = out_valido_q;
  assign Resultado = resultado_q;
  assign DivCero   = divcero_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed bench for divisor_secuencial: vector table plus backpressure and mid-operation reset sequences.
module tb_divisor_secuencial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        InValido = 1'b0;
  logic        InListo;
  logic [31:0] Operando1 = '0;
  logic [31:0] Operando2 = '0;
  logic        ConSigno = 1'b0;
  logic        PideResto = 1'b0;
  logic        OutValido;
  logic        OutListo = 1'b0;
  logic [31:0] Resultado;
  logic        DivCero;

  int n_pass = 0;
  int n_total = 0;

  divisor_secuencial #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .InValido(InValido), .InListo(InListo),
    .Operando1(Operando1), .Operando2(Operando2),
    .ConSigno(ConSigno), .PideResto(PideResto),
    .OutValido(OutValido), .OutListo(OutListo),
    .Resultado(Resultado), .DivCero(DivCero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        sgn;
    logic        rem;
    logic [31:0] res;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Accept a request (waiting for InListo), returning the number of cycles until OutValido.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic r, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!InListo && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("wait_inlisto", {31'b0, InListo}, 32'd1);
    Operando1 = a; Operando2 = b; ConSigno = s; PideResto = r; InValido = 1'b1;
    @(posedge clk);
    #1;
    InValido = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!OutValido && lat < 100);
  endtask

  task automatic consume();
    OutListo = 1'b1;
    @(posedge clk);
    #1;
    OutListo = 1'b0;
    chk("consume_outvalido", {31'b0, OutValido}, 32'd0);
    chk("consume_inlisto", {31'b0, InListo}, 32'd1);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 1'b0, 34};
    vecs[1]  = '{32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 1'b0, 34};
    vecs[2]  = '{32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 32'hFFFFFFFD, 1'b0, 34};
    vecs[3]  = '{32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 34};
    vecs[4]  = '{32'h12345678, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1};
    vecs[5]  = '{32'h12345678, 32'd0, 1'b1, 1'b1, 32'h12345678, 1'b1, 1};
    vecs[6]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, 1'b0, 1};
    vecs[7]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'd0, 1'b0, 1};
    vecs[8]  = '{32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, 32'hFFFFFFFD, 1'b0, 34};
    vecs[9]  = '{32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, 32'd1, 1'b0, 34};
    vecs[10] = '{32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 32'h7FFFFFFC, 1'b0, 34};
    vecs[11] = '{32'hFFFFFFF9, 32'd2, 1'b0, 1'b1, 32'd1, 1'b0, 34};
    vecs[12] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0, 1'b0, 34};
    vecs[13] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0, 34};
    vecs[14] = '{32'hFFFFFFEC, 32'hFFFFFFFA, 1'b1, 1'b0, 32'd3, 1'b0, 34};
    vecs[15] = '{32'hFFFFFFEC, 32'hFFFFFFFA, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 34};
    vecs[16] = '{32'd5, 32'd9, 1'b0, 1'b0, 32'd0, 1'b0, 34};
    vecs[17] = '{32'd5, 32'd9, 1'b0, 1'b1, 32'd5, 1'b0, 34};
    vecs[18] = '{32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 34};
    vecs[19] = '{32'h0000000C, 32'hFFFFFFFD, 1'b1, 1'b1, 32'd0, 1'b0, 34};

    #12;
    chk("reset_inlisto", {31'b0, InListo}, 32'd1);
    chk("reset_outvalido", {31'b0, OutValido}, 32'd0);
    chk("reset_resultado", Resultado, 32'd0);
    chk("reset_divcero", {31'b0, DivCero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      issue(vecs[i].op1, vecs[i].op2, vecs[i].sgn, vecs[i].rem, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_resultado", i), Resultado, vecs[i].res);
      chk($sformatf("v%0d_divcero", i), {31'b0, DivCero}, {31'b0, vecs[i].dz});
      consume();
    end

    // Result must hold under backpressure while new requests are offered.
    issue(32'd100, 32'd7, 1'b0, 1'b0, lat);
    chk("bp_latency", 32'(lat), 32'd34);
    for (int c = 0; c < 10; c++) begin
      Operando1 = $urandom; Operando2 = $urandom_range(1, 50);
      PideResto = c[0]; InValido = ~c[0];
      @(posedge clk);
      #1;
      chk("bp_resultado", Resultado, 32'd14);
      chk("bp_inlisto", {31'b0, InListo}, 32'd0);
      chk("bp_outvalido", {31'b0, OutValido}, 32'd1);
    end
    InValido = 1'b0;
    consume();
    @(posedge clk);
    #1;
    chk("bp_no_spurious_accept", {31'b0, InListo}, 32'd1);

    // Abort the request mid-iteration with an asynchronous reset.
    @(negedge clk);
    Operando1 = 32'd100; Operando2 = 32'd7; ConSigno = 1'b0; PideResto = 1'b0; InValido = 1'b1;
    @(posedge clk);
    #1;
    InValido = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_inlisto", {31'b0, InListo}, 32'd1);
    chk("rst_outvalido", {31'b0, OutValido}, 32'd0);
    chk("rst_resultado", Resultado, 32'd0);
    chk("rst_divcero", {31'b0, DivCero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (OutValido) seen = 1'b1;
      end
      chk("rst_no_result", {31'b0, seen}, 32'd0);
    end
    chk("rst_inlisto_after", {31'b0, InListo}, 32'd1);
    issue(32'd9, 32'd3, 1'b0, 1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'd34);
    chk("post_rst_resultado", Resultado, 32'd3);
    consume();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
